// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - handshake bundle for the product accumulator
// Purpose: groups frame control, the product input stream and the result
//   output stream of the product accumulator into one port.
// Signals:
//   start     frame-start pulse (master -> slave)
//   in_valid  product valid     (master -> slave)
//   in_ready  product accepted  (slave -> master)
//   in_prod   PW-bit product    (master -> slave)
//   out_valid result valid      (slave -> master)
//   out_ready result accepted   (master -> slave)
//   out_sum   AW-bit frame sum  (slave -> master)
//   out_ovf   frame overflowed  (slave -> master)
//   busy      frame in progress (slave -> master)
interface product_accumulator_if #(
  parameter int PW = 8,
  parameter int AW = 16
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_prod;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          out_ovf;
  logic          busy;

  modport master (
    output start, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  start, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - frame accumulator for multiplier products
// Purpose: sums LEN unsigned PW-bit products per frame into an AW-bit
//   accumulator and presents the total on a valid/ready result port.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    product_accumulator_if.slave (start, in_* stream, out_* stream, busy)
// Build option: ACC_SATURATE_EN - clamp the accumulator at 2^AW-1 on carry-out
//   instead of wrapping modulo 2^AW.
module product_accumulator #(
  parameter int PW  = 8,
  parameter int AW  = 16,
  parameter int LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  product_accumulator_if.slave  bus
);

  localparam int            CW   = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic [AW:0]   w_sum;
  logic [AW-1:0] w_acc_next;

  // One extra bit so the carry-out is visible for the overflow flag.
  assign w_sum = {1'b0, r_acc} + {{(AW + 1 - PW){1'b0}}, bus.in_prod};

`ifdef ACC_SATURATE_EN
  // Once clamped, any further nonzero add carries again, so the accumulator
  // stays at full scale for the rest of the frame.
  assign w_acc_next = w_sum[AW] ? {AW{1'b1}} : w_sum[AW-1:0];
`else
  assign w_acc_next = w_sum[AW-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          // in_ready is 1 throughout ACC, so in_valid alone marks acceptance.
          if (bus.in_valid) begin
            r_acc <= w_acc_next;
            r_ovf <= r_ovf | w_sum[AW];
            if (r_count == LAST) begin
              r_state <= S_DONE;
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
        end
        S_DONE: begin
          // start is deliberately not looked at here, even on the handshake.
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // All outputs come straight from registers; nothing depends on inputs.
  assign bus.in_ready  = (r_state == S_ACC);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_sum   = r_acc;
  assign bus.out_ovf   = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Three instances: 0 = default (AW=16, LEN=4), 1 = AW=9 LEN=4, 2 = AW=16 LEN=1
  logic [2:0]  start_d, valid_d, ready_d;
  logic [7:0]  prod_d [3];
  logic [2:0]  in_ready_o, out_valid_o, ovf_o, busy_o;
  logic [15:0] sum_o [3];

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  typedef struct {
    int          inst;
    int unsigned sum;
    int unsigned ovf;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int AWG  = (g == 1) ? 9 : 16;
    localparam int LENG = (g == 2) ? 1 : 4;
    product_accumulator_if #(.PW(8), .AW(AWG)) bus ();
    assign bus.start     = start_d[g];
    assign bus.in_valid  = valid_d[g];
    assign bus.in_prod   = prod_d[g];
    assign bus.out_ready = ready_d[g];
    assign in_ready_o[g]  = bus.in_ready;
    assign out_valid_o[g] = bus.out_valid;
    assign ovf_o[g]       = bus.out_ovf;
    assign busy_o[g]      = bus.busy;
    assign sum_o[g]       = 16'(bus.out_sum);
    product_accumulator #(.PW(8), .AW(AWG), .LEN(LENG)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic chk(string name, int unsigned act, int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the frame total is the plain sum of its products; a carry
  // happened somewhere iff that sum reaches 2^AW.
  task automatic push(int k, int unsigned total);
    exp_t        e;
    int unsigned lim;
    lim    = (k == 1) ? 512 : 65536;
    e.inst = k;
    e.ovf  = (total >= lim) ? 1 : 0;
`ifdef ACC_SATURATE_EN
    e.sum  = (total >= lim) ? lim - 1 : total;
`else
    e.sum  = total % lim;
`endif
    exp_q.push_back(e);
  endtask

  // Monitor: pops an expectation whenever a result handshake is presented.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (out_valid_o[k] && ready_d[k]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result_inst", k, e.inst);
          chk("out_sum", sum_o[k], e.sum);
          chk("out_ovf", ovf_o[k], e.ovf);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(int k);
    start_d[k] = 1'b1;
    cyc();
    start_d[k] = 1'b0;
  endtask

  task automatic send(int k, int p, int gap);
    bit rdy;
    int n;
    n = 0;
    valid_d[k] = 1'b1;
    prod_d[k]  = 8'(p);
    do begin
      rdy = in_ready_o[k];
      cyc();
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("accept_timeout", 0, 1);
    valid_d[k] = 1'b0;
    prod_d[k]  = 8'($urandom);
    repeat (gap) cyc();
  endtask

  task automatic wait_valid(int k, output int at);
    int n;
    n = 0;
    while (!out_valid_o[k] && n < 50) begin
      cyc();
      n++;
    end
    if (!out_valid_o[k]) chk("valid_timeout", 0, 1);
    at = cyc_n;
  endtask

  task automatic handshake(int k, bit rnd);
    bit hs;
    int n;
    n = 0;
    do begin
      ready_d[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = out_valid_o[k] && ready_d[k];
      cyc();
      n++;
    end while (!hs && n < 100);
    ready_d[k] = 1'b0;
    if (!hs) chk("result_timeout", 0, 1);
    else     chk("idle_after_accept", busy_o[k], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tv, len, k;
    int unsigned tot;
    int prods[$];

    start_d = '0; valid_d = '0; ready_d = '0;
    for (int i = 0; i < 3; i++) prod_d[i] = 8'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) cyc();
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", in_ready_o[i], 0);
      chk("rst_out_valid", out_valid_o[i], 0);
      chk("rst_out_sum", sum_o[i], 0);
      chk("rst_out_ovf", ovf_o[i], 0);
      chk("rst_busy", busy_o[i], 0);
    end
    rst_n = 1'b1;
    cyc();

    // Basic frame with latency check
    ready_d[0] = 1'b1;
    push(0, 900);
    t0 = cyc_n;
    start_frame(0);
    chk("busy_after_start", busy_o[0], 1);
    chk("ready_after_start", in_ready_o[0], 1);
    repeat (4) send(0, 225, 0);
    wait_valid(0, tv);
    chk("basic_latency", tv - t0, 5);
    cyc();
    chk("basic_idle", busy_o[0], 0);
    ready_d[0] = 1'b0;

    // Input gaps and result backpressure
    push(0, 10);
    start_frame(0);
    for (int i = 1; i <= 4; i++) send(0, i, 2);
    wait_valid(0, tv);
    repeat (5) begin
      chk("hold_valid", out_valid_o[0], 1);
      chk("hold_sum", sum_o[0], 10);
      chk("done_in_ready", in_ready_o[0], 0);
      cyc();
    end
    ready_d[0] = 1'b1;
    cyc();
    chk("bp_idle_busy", busy_o[0], 0);
    chk("bp_idle_valid", out_valid_o[0], 0);
    ready_d[0] = 1'b0;

    // Reset in the middle of a frame
    start_frame(0);
    send(0, 7, 0);
    send(0, 8, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_o[0], 0);
    chk("midrst_in_ready", in_ready_o[0], 0);
    chk("midrst_out_valid", out_valid_o[0], 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    push(0, 20);
    start_frame(0);
    repeat (4) send(0, 5, 0);
    handshake(0, 1'b0);

    // start during ACC and on the DONE handshake edge is ignored
    push(0, 100);
    start_frame(0);
    send(0, 10, 0);
    send(0, 20, 0);
    start_d[0] = 1'b1;
    send(0, 30, 0);
    start_d[0] = 1'b0;
    send(0, 40, 0);
    wait_valid(0, tv);
    cyc();
    ready_d[0] = 1'b1;
    start_d[0] = 1'b1;
    cyc();
    start_d[0] = 1'b0;
    ready_d[0] = 1'b0;
    repeat (3) begin
      chk("no_restart_busy", busy_o[0], 0);
      chk("no_restart_ready", in_ready_o[0], 0);
      cyc();
    end

    // Overflow with a 9-bit accumulator
    push(1, 900);
    start_frame(1);
    repeat (4) send(1, 225, 0);
    handshake(1, 1'b0);

    // Single-product frames
    push(2, 200);
    t0 = cyc_n;
    start_frame(2);
    send(2, 200, 0);
    wait_valid(2, tv);
    chk("len1_latency", tv - t0, 2);
    handshake(2, 1'b0);

    // Randomized frames across all instances
    for (int f = 0; f < 30; f++) begin
      k   = f % 3;
      len = (k == 2) ? 1 : 4;
      prods.delete();
      tot = 0;
      for (int i = 0; i < len; i++) begin
        prods.push_back($urandom_range(0, 3) == 0 ? 255 : int'($urandom_range(0, 255)));
        tot += prods[i];
      end
      push(k, tot);
      start_frame(k);
      foreach (prods[i]) send(k, prods[i], $urandom_range(0, 2));
      handshake(k, 1'b1);
      repeat ($urandom_range(0, 2)) cyc();
    end

    repeat (2) cyc();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Stream accumulator directly downstream of the 4x4 tree multiplier. It consumes a frame of LEN unsigned products over a valid/ready handshake and sums them into an AW-bit accumulator. It presents the frame total on an output valid/ready handshake. Together with the multiplier it forms the dot-product / MAC path.

## Interface
- PW, 8, product width; matches the multiplier output P.
- AW, 16, accumulator and result width; AW >= PW.
- LEN, 4, products per frame; LEN >= 1.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset (single clock domain; reset asserts asynchronously).
- start  in  1  frame-start pulse; honoured only in IDLE.
- in_valid  in  1  in_prod is valid.
- in_ready  out  1  block accepts a product this cycle.
- in_prod  in  PW  unsigned product from the multiplier.
- out_valid  out  1  out_sum/out_ovf are valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  AW  frame total.
- out_ovf  out  1  sticky: an addition in this frame exceeded AW bits.
- busy  out  1  state != IDLE.

## Operation
- The FSM has three states: IDLE, ACC, DONE.
- **IDLE:** in_ready=0, out_valid=0.
  - On start=1: clear acc, clear count, clear ovf, then go to ACC.
- **ACC:** in_ready=1, taken directly from the state register.
  - A product is accepted when in_valid & in_ready.
  - On acceptance: acc <= acc + zero-extended in_prod, and count increments.
  - When the accepted product is number LEN (count == LEN-1), go to DONE.
  - Cycles with in_valid=0 hold all state.
- **DONE:** out_valid=1, out_sum=acc, out_ovf=ovf, in_ready=0.
  - All three outputs hold stable until out_valid & out_ready, then go to IDLE.
- start is ignored in ACC and DONE. That includes start arriving in the same cycle as the DONE->IDLE handshake.
- **Arithmetic:** compute the AW+1-bit sum {1'b0,acc} + in_prod.
  - A carry-out sets ovf, which is sticky until the next start.
  - The behaviour of acc on overflow is set by the Configuration section.
- in_prod is ignored whenever in_ready=0.
- **LEN=1:** a single accepted product goes ACC->DONE.
- **Reset:** asserting rst_n at any point, including mid-frame or in DONE, returns the block to IDLE immediately.
  - acc, count and ovf clear to 0.
  - Any partial frame is discarded. No output is produced for it.

## Timing
- Reset values: in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
- start sampled at edge t: busy=1 and in_ready=1 from t+1.
- Throughput is one product per cycle with no bubbles inside ACC.
- Last product accepted at edge t: out_valid=1 from t+1, and out_sum includes that product.
- Minimum frame latency from start to out_valid is LEN+1 cycles.
- Result accepted at edge t: back in IDLE at t+1. The earliest new start is sampled at t+1.
- All outputs are registered or decoded from the state register. There are no combinational paths from inputs to outputs.

## Configuration
- `ACC_SATURATE_EN`, when defined: on carry-out, acc clamps to 2^AW-1 and stays there for the rest of the frame. ovf=1.
- When not defined: acc wraps modulo 2^AW. ovf=1 still flags the wrap.

## Test plan
- **Basic frame:** LEN=4, AW=16. Send start, then products 225,225,225,225 back-to-back, out_ready=1.
  - Expect out_valid=1 exactly 5 cycles after start, with out_sum=900 and out_ovf=0.
- **Input gaps and backpressure:** products 1,2,3,4 with in_valid low for 2 cycles between each. Hold out_ready=0 for 5 cycles.
  - Expect out_sum=10 held stable with out_valid=1 throughout.
  - Expect in_ready=0 in DONE.
  - Expect IDLE one cycle after out_ready rises.
- **Overflow:** AW=9, products 225x4.
  - Without macro: expect out_sum=388, out_ovf=1.
  - With ACC_SATURATE_EN: expect out_sum=511, out_ovf=1.
- **Reset mid-frame:** pull rst_n low after 2 of 4 products.
  - Expect busy=0, in_ready=0, out_valid=0 immediately.
  - A subsequent frame of 5,5,5,5 gives out_sum=20, out_ovf=0.
- **Ignored start:** pulse start during ACC and during the DONE handshake cycle.
  - Expect no clear of acc (frame 10,20,30,40 gives 100).
  - Expect no new frame begun after the return to IDLE.
- **LEN=1:** start, then product 200.
  - Expect out_valid 2 cycles after start, with out_sum=200.
